// File: rtl/context_pkg.sv
// Shared definitions for the context save/restore engine: FSM encoding,
// register-index width and the PC-mirror register index.
package context_pkg;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int IDX_W            = 5;
  localparam int PC_MIRROR_IDX    = 28;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/context_index_counter.sv
// Register index counter for context transfers: clear, increment, terminal flag.
// With CONTEXT_SKIP_PC_REG_EN defined the increment steps over the PC mirror index.
module context_index_counter
  import context_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [IDX_W-1:0] next_index;

  always_comb begin
    next_index = index + IDX_W'(1);
`ifdef CONTEXT_SKIP_PC_REG_EN
    // The PC mirror is rewritten by hardware, so its slot is never transferred.
    if (next_index == IDX_W'(PC_MIRROR_IDX)) next_index = index + IDX_W'(2);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n)   index <= '0;
    else if (clear) index <= '0;
    else if (inc)   index <= next_index;
  end

  assign last = (index == LAST_IDX);

endmodule

// File: rtl/context_switcher.sv
// Copies the register file to a memory frame (save) or back (restore).
// Optional build macro: CONTEXT_SKIP_PC_REG_EN (skip the PC mirror register).
module context_switcher
  import context_pkg::*;
#(
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_save,
  input  logic                  start_restore,
  input  logic [MEM_ADDR_W-1:0] base_address,
  output logic [4:0]            rf_read_address,
  input  logic [31:0]           rf_read_data,
  output logic [4:0]            rf_write_address,
  output logic [31:0]           rf_write_data,
  output logic                  rf_write_enable,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_read_data,
  output logic                  busy,
  output logic                  done,
  output state_t                fsm_state
);

  state_t                state, next_state;
  logic [MEM_ADDR_W-1:0] base_reg;
  logic                  drain;
  logic                  wr_pending;
  logic [IDX_W-1:0]      wr_index;
  logic [IDX_W-1:0]      index;
  logic                  last;
  logic                  issuing;
  logic                  clear_idx;

  assign issuing   = (state == SAVE) || ((state == RESTORE) && !drain);
  assign clear_idx = (state == IDLE) || (state == FINISH);

  context_index_counter #(
    .NUM_REGS(NUM_REGS)
  ) u_index (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear_idx),
    .inc    (issuing),
    .index  (index),
    .last   (last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_save)         next_state = SAVE;
        else if (start_restore) next_state = RESTORE;
      end
      SAVE:    if (last)  next_state = FINISH;
      RESTORE: if (drain) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Restore is a two-stage pipe: address out in one cycle, register write the
  // next; drain is the extra cycle that retires the final read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      base_reg   <= '0;
      drain      <= 1'b0;
      wr_pending <= 1'b0;
      wr_index   <= '0;
    end else begin
      if ((state == IDLE) && (start_save || start_restore)) base_reg <= base_address;
      drain      <= (state == RESTORE) && (drain || last);
      wr_pending <= (state == RESTORE) && !drain;
      wr_index   <= index;
    end
  end

  always_comb begin
    rf_read_address  = '0;
    rf_write_address = '0;
    rf_write_data    = '0;
    rf_write_enable  = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    busy             = (state != IDLE);
    done             = (state == FINISH);
    case (state)
      SAVE: begin
        rf_read_address  = index;
        mem_address      = base_reg + MEM_ADDR_W'(index);
        mem_write_data   = rf_read_data;
        mem_write_enable = 1'b1;
      end
      RESTORE: begin
        if (!drain) mem_address = base_reg + MEM_ADDR_W'(index);
        if (wr_pending) begin
          rf_write_enable  = 1'b1;
          rf_write_address = wr_index;
          rf_write_data    = mem_read_data;
        end
      end
      default: ;
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_context_switcher.sv
// Directed bench for context_switcher with behavioural register file and memory.
module tb_context_switcher;
  import context_pkg::*;

`ifdef CONTEXT_SKIP_PC_REG_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int XFER         = SKIP ? 31 : 32;
  localparam int SAVE_DONE    = XFER + 1;
  localparam int RESTORE_DONE = XFER + 2;

  logic        clock;
  logic        reset_n;
  logic        start_save;
  logic        start_restore;
  logic [9:0]  base_address;
  logic [4:0]  rf_read_address;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  context_switcher dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start_save      (start_save),
    .start_restore   (start_restore),
    .base_address    (base_address),
    .rf_read_address (rf_read_address),
    .rf_read_data    (rf_read_data),
    .rf_write_address(rf_write_address),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_read_data   (mem_read_data),
    .busy            (busy),
    .done            (done),
    .fsm_state       (fsm_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural register file and memory
  logic [31:0] mem [0:1023];
  logic [31:0] rf  [0:31];
  logic        fill_req;
  logic        poke_en;
  logic [9:0]  poke_addr;
  logic [31:0] poke_data;
  logic        rf_load;
  int          rf_kind;

  function automatic logic [31:0] fill_val(input int a);
    return 32'hFFFF_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] rf_pat(input int kind, input int i);
    case (kind)
      0:       return 32'(i * 3);
      1:       return 32'h1111_0000 + 32'(i);
      default: return 32'(i * 7 + 1);
    endcase
  endfunction

  always @(posedge clock) begin
    if (fill_req) begin
      for (int a = 0; a < 1024; a++) mem[a] <= fill_val(a);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
    end
    mem_read_data <= mem[mem_address];
  end

  always @(posedge clock) begin
    if (rf_load) begin
      for (int r = 0; r < 32; r++) rf[r] <= rf_pat(rf_kind, r);
    end else if (rf_write_enable) begin
      rf[rf_write_address] <= rf_write_data;
    end
  end

  assign rf_read_data = rf[rf_read_address];

  // Scoreboard counters and cycle monitor
  int checks = 0;
  int errors = 0;
  int cyc, done_cyc, n_done, n_busy, n_rfwe, n_memwe, both_we, last_rfwe_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; done_cyc = -1; n_done = 0; n_busy = 0;
    n_rfwe = 0; n_memwe = 0; both_we = 0; last_rfwe_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (busy) n_busy++;
    if (rf_write_enable) begin
      n_rfwe++;
      last_rfwe_cyc = cyc;
    end
    if (mem_write_enable) n_memwe++;
    if (rf_write_enable && mem_write_enable) both_we++;
  endtask

  task automatic wait_done(input int max);
    while (done_cyc < 0 && cyc < max) tick();
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    tick();
  endtask

  task automatic raw_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_mem();
    fill_req = 1'b1;
    raw_cycle();
    fill_req = 1'b0;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = 10'(a);
    poke_data = d;
    raw_cycle();
    poke_en = 1'b0;
  endtask

  task automatic load_rf(input int kind);
    rf_kind = kind;
    rf_load = 1'b1;
    raw_cycle();
    rf_load = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    reset_n = 1'b0; start_save = 1'b0; start_restore = 1'b0; base_address = '0;
    fill_req = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    rf_load = 1'b0; rf_kind = 0;
    clear_mon();
    repeat (2) raw_cycle();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", {30'd0, mem_write_enable, rf_write_enable}, 32'd0);
    check("rst_addr", {17'd0, mem_address, rf_read_address}, 32'd0);
    check("rst_data", mem_write_data | rf_write_data | 32'(rf_write_address), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    reset_n = 1'b1;

    // Save base 100, PC slot preset
    load_rf(0);
    fill_mem();
    poke(128, 32'hDEAD_BEEF);
    clear_mon();
    base_address = 10'd100;
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    check("save_c1_addr", 32'(mem_address), 32'd100);
    check("save_c1_we", 32'(mem_write_enable), 32'd1);
    check("save_c1_state", 32'(fsm_state), 32'(SAVE));
    wait_done(60);
    check("save_done_cyc", 32'(done_cyc), 32'(SAVE_DONE));
    check("save_done_cnt", 32'(n_done), 32'd1);
    check("save_busy_cyc", 32'(n_busy), 32'(SAVE_DONE));
    check("save_memwe_cnt", 32'(n_memwe), 32'(XFER));
    check("save_both_we", 32'(both_we), 32'd0);
    check("save_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      exp_w = (SKIP && i == 28) ? 32'hDEAD_BEEF : rf_pat(0, i);
      check($sformatf("save_mem%0d", i), mem[100 + i], exp_w);
    end
    check("save_mem99", mem[99], fill_val(99));
    check("save_mem132", mem[132], fill_val(132));

    // Restore base 200
    load_rf(1);
    fill_mem();
    for (int i = 0; i < 32; i++) poke(200 + i, 32'hA500_0000 + 32'(i));
    clear_mon();
    base_address = 10'd200;
    start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    check("rest_c1_addr", 32'(mem_address), 32'd200);
    check("rest_c1_rfwe", 32'(rf_write_enable), 32'd0);
    tick();
    check("rest_c2_rfwe", 32'(rf_write_enable), 32'd1);
    check("rest_c2_rfaddr", 32'(rf_write_address), 32'd0);
    check("rest_c2_rfdata", rf_write_data, 32'hA500_0000);
    check("rest_c2_addr", 32'(mem_address), 32'd201);
    check("rest_c2_memwe", 32'(mem_write_enable), 32'd0);
    wait_done(60);
    check("rest_done_cyc", 32'(done_cyc), 32'(RESTORE_DONE));
    check("rest_last_wr", 32'(last_rfwe_cyc), 32'(RESTORE_DONE - 1));
    check("rest_rfwe_cnt", 32'(n_rfwe), 32'(XFER));
    check("rest_memwe_cnt", 32'(n_memwe), 32'd0);
    check("rest_both_we", 32'(both_we), 32'd0);
    for (int i = 0; i < 32; i++) begin
      exp_w = (SKIP && i == 28) ? rf_pat(1, 28) : 32'hA500_0000 + 32'(i);
      check($sformatf("rest_rf%0d", i), rf[i], exp_w);
    end

    // Both starts together, then a restore request mid-save
    load_rf(2);
    fill_mem();
    clear_mon();
    base_address = 10'd300;
    start_save = 1'b1;
    start_restore = 1'b1;
    tick();
    start_save = 1'b0;
    start_restore = 1'b0;
    check("both_state", 32'(fsm_state), 32'(SAVE));
    repeat (3) tick();
    start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    wait_done(60);
    check("both_done_cyc", 32'(done_cyc), 32'(SAVE_DONE));
    tick();
    tick();
    check("both_no_restore", 32'(busy), 32'd0);
    check("both_rfwe_cnt", 32'(n_rfwe), 32'd0);
    for (int i = 0; i < 32; i++) begin
      exp_w = (SKIP && i == 28) ? fill_val(328) : rf_pat(2, i);
      check($sformatf("both_mem%0d", i), mem[300 + i], exp_w);
    end

    // Address wrap from base 1020
    fill_mem();
    clear_mon();
    base_address = 10'd1020;
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    check("wrap_c1_addr", 32'(mem_address), 32'd1020);
    repeat (4) tick();
    check("wrap_c5_addr", 32'(mem_address), 32'd0);
    wait_done(60);
    check("wrap_done_cyc", 32'(done_cyc), 32'(SAVE_DONE));
    for (int i = 0; i < 32; i++) begin
      exp_w = (SKIP && i == 28) ? fill_val(24) : rf_pat(2, i);
      check($sformatf("wrap_mem%0d", i), mem[(1020 + i) % 1024], exp_w);
    end
    check("wrap_mem1019", mem[1019], fill_val(1019));
    check("wrap_mem28", mem[28], fill_val(28));

    // Reset during save, just before index 10
    fill_mem();
    clear_mon();
    base_address = 10'd400;
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    repeat (9) tick();
    check("abort_c10_addr", 32'(mem_address), 32'd409);
    reset_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", {30'd0, mem_write_enable, rf_write_enable}, 32'd0);
    check("abort_addr", 32'(mem_address), 32'd0);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_mem409", mem[409], rf_pat(2, 9));
    check("abort_mem410", mem[410], fill_val(410));
    check("abort_mem431", mem[431], fill_val(431));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
